// File: rtl/ctrl_opcode_encoder.sv
// Re-encodes a decoded RV32I control bundle into its 7-bit opcode and queues
// {illegal, opcode} in a trace FIFO, with sticky overflow and illegal statistics.
module ctrl_opcode_encoder #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     ALUSrc,
  input  logic                     MemtoReg,
  input  logic                     RegWrite,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  input  logic [1:0]               ALUOp,
  input  logic                     Branch,
  input  logic                     JSel,
  input  logic                     JalrSel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [6:0]               out_opcode,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         illegal_count,
  input  logic                     clear_stats
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

  // Bundle order: {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,ALUOp,Branch,JSel,JalrSel}
  localparam logic [9:0] B_R    = 10'b0_0_1_0_0_10_0_0_0;
  localparam logic [9:0] B_I    = 10'b1_0_1_0_0_10_0_0_0;
  localparam logic [9:0] B_LUI  = 10'b1_0_1_0_0_11_0_0_0;
  localparam logic [9:0] B_LW   = 10'b1_1_1_1_0_00_0_0_0;
  localparam logic [9:0] B_SW   = 10'b1_0_0_0_1_00_0_0_0;
  localparam logic [9:0] B_BEQ  = 10'b0_0_0_0_0_01_1_0_0;
  localparam logic [9:0] B_JALR = 10'b0_0_0_0_0_00_0_1_1;
  localparam logic [9:0] B_JAL  = 10'b0_0_0_0_0_00_0_1_0;

  logic [9:0]       bundle;
  logic [6:0]       opcode;
  logic             illegal;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign bundle = {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, Branch, JSel, JalrSel};

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    opcode  = 7'b000_0000;
    illegal = 1'b0;
    case (bundle)
      B_R:     opcode = 7'b011_0011;
      B_I:     opcode = 7'b001_0011;
      B_LUI:   opcode = 7'b011_0111;
      B_LW:    opcode = 7'b000_0011;
      B_SW:    opcode = 7'b010_0011;
      B_BEQ:   opcode = 7'b110_0011;
      B_JALR:  opcode = 7'b110_0111;
      B_JAL:   opcode = 7'b110_1111;
      default: illegal = 1'b1;
    endcase
  end

  assign full      = (level == FULL_LEVEL);
  assign empty     = (level == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = out_valid && out_ready;

  // NOTE: the storage array has no reset; the head is masked to zero while
  // empty, so stale or uninitialised entries never reach the outputs.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {illegal, opcode};
  end

  assign out_opcode  = empty ? 7'b000_0000 : mem[rd_ptr][6:0];
  assign out_illegal = empty ? 1'b0 : mem[rd_ptr][7];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // clear_stats wins over a same-cycle set or increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow      <= 1'b0;
      illegal_count <= '0;
    end else if (clear_stats) begin
      overflow      <= 1'b0;
      illegal_count <= '0;
    end else begin
      if (in_valid && full) overflow <= 1'b1;
      if (push && illegal && (illegal_count != '1)) illegal_count <= illegal_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ctrl_opcode_encoder.sv
// Directed self-checking bench for ctrl_opcode_encoder: encode table, FIFO
// ordering and full/empty boundaries, sticky statistics and async reset.
module tb_ctrl_opcode_encoder;

  localparam int DEPTH = 8;
  localparam int CNT_W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite;
  logic [1:0] ALUOp;
  logic       Branch, JSel, JalrSel;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_opcode;
  logic       out_illegal;
  logic [3:0] level;
  logic       overflow;
  logic [7:0] illegal_count;
  logic       clear_stats;
  logic [9:0] bun;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] model [$];

  // {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,ALUOp,Branch,JSel,JalrSel}
  logic [9:0] legal_b [8] = '{10'b0010010000, 10'b1010010000, 10'b1010011000, 10'b1111000000,
                              10'b1000100000, 10'b0000001100, 10'b0000000011, 10'b0000000010};
  logic [6:0] legal_op [8] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0000011,
                               7'b0100011, 7'b1100011, 7'b1100111, 7'b1101111};
  localparam logic [9:0] B_LW    = 10'b1111000000;
  localparam logic [9:0] B_SW    = 10'b1000100000;
  localparam logic [9:0] B_JAL   = 10'b0000000010;
  localparam logic [9:0] B_ZERO  = 10'b0000000000;
  localparam logic [9:0] B_ALUSRC = 10'b1000000000;

  assign {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, Branch, JSel, JalrSel} = bun;

  ctrl_opcode_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .ALUOp(ALUOp), .Branch(Branch), .JSel(JSel), .JalrSel(JalrSel),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_illegal(out_illegal), .level(level), .overflow(overflow),
    .illegal_count(illegal_count), .clear_stats(clear_stats)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it, inputs changed there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    logic [7:0] exp;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int c = 0; c < DEPTH + 4 && out_valid; c++) begin
      exp = (model.size() != 0) ? model.pop_front() : 8'hFF;
      check(tag, {24'd0, out_illegal, out_opcode}, {24'd0, exp});
      step();
    end
    check({tag, "_left"}, model.size(), 0);
    check({tag, "_empty"}, out_valid, 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clear_stats = 1'b0; bun = B_ZERO;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_count", illegal_count, 0);
    check("rst_head", {out_illegal, out_opcode}, 0);
    #20 reset = 1'b0;
    step();

    // Legal sweep, one per cycle, reader always ready.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bun = legal_b[i];
      step();
      check($sformatf("sweep_op%0d", i), {out_valid, out_illegal, out_opcode}, {2'b10, legal_op[i]});
    end
    in_valid = 1'b0;
    step();
    check("sweep_empty", out_valid, 0);
    check("sweep_count", illegal_count, 0);

    // Two illegal bundles.
    in_valid = 1'b1;
    bun = B_ZERO;
    step();
    check("ill_zero", {out_valid, out_illegal, out_opcode}, 9'b1_1_0000000);
    bun = B_ALUSRC;
    step();
    check("ill_alusrc", {out_valid, out_illegal, out_opcode}, 9'b1_1_0000000);
    in_valid = 1'b0;
    step();
    check("ill_count2", illegal_count, 2);
    clear_stats = 1'b1; step(); clear_stats = 1'b0;
    check("clear_count", illegal_count, 0);

    // Overfill with reader stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    bun = B_LW;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i < 8) model.push_back({1'b0, 7'b0000011});
      check($sformatf("fill_level%0d", i), level, (i < 7) ? i + 1 : 8);
      if (i == 7) begin
        check("fill_in_ready", in_ready, 0);
        check("fill_no_ovf", overflow, 0);
      end
      if (i == 8) check("fill_ovf", overflow, 1);
    end
    drain("drain_lw");

    // Full with simultaneous pop: push dropped, then accepted next cycle.
    clear_stats = 1'b1; step(); clear_stats = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; bun = B_SW;
    for (int i = 0; i < 8; i++) begin
      step();
      model.push_back({1'b0, 7'b0100011});
    end
    bun = B_JAL; out_ready = 1'b1;
    step();
    void'(model.pop_front());
    check("fullpop_level", level, 7);
    check("fullpop_ovf", overflow, 1);
    out_ready = 1'b0;
    step();
    model.push_back({1'b0, 7'b1101111});
    check("fullpop_refill", level, 8);
    drain("drain_fullpop");

    // Steady push+pop at level 3 across pointer wrap.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bun = legal_b[i];
      step();
      model.push_back({1'b0, legal_op[i]});
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bun = legal_b[(3 + k) % 8];
      check($sformatf("stream_head%0d", k), {out_illegal, out_opcode}, model[0]);
      step();
      void'(model.pop_front());
      model.push_back({1'b0, legal_op[(3 + k) % 8]});
      check($sformatf("stream_level%0d", k), level, 3);
    end
    drain("drain_stream");

    // Build level 5, overflow=1, illegal_count=4, then reset mid-stream.
    clear_stats = 1'b1; step(); clear_stats = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1;
    bun = B_ZERO; repeat (4) step();
    bun = B_LW;   repeat (5) step();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    check("pre_rst_level", level, 5);
    check("pre_rst_ovf", overflow, 1);
    check("pre_rst_count", illegal_count, 4);
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_count", illegal_count, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_head", {out_illegal, out_opcode}, 0);
    #2 reset = 1'b0;
    step();

    // Counter saturation, then clear_stats beating a same-cycle increment.
    out_ready = 1'b1; in_valid = 1'b1; bun = B_ZERO;
    repeat (255) step();
    check("sat_255", illegal_count, 255);
    repeat (3) step();
    check("sat_hold", illegal_count, 255);
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    check("sat_clear", illegal_count, 0);
    in_valid = 1'b0;
    step();
    check("final_empty", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
